// File: rtl/pwm_switch_array.sv
// pwm_switch_array: multi-channel PWM pulse generator for photonic-switch coils.
// A prescaler produces a strobe every DIV clocks; the strobe advances a shared
// period counter. Each channel emits one-clock set/reset pulses when the counter
// matches its compare values, and keeps a latched level. Period and compare
// values are double-buffered and only change at a period boundary.
//
// Ports:
//   clk        core clock
//   reset      synchronous active-high reset
//   en         run enable; low freezes prescaler, counter and levels
//   period     counter terminal value (period length = period+1 ticks)
//   set_val    per-channel set compare, channel i at [i*W +: W]
//   rst_val    per-channel reset compare, same packing
//   load       capture period/set_val/rst_val into the shadow registers
//   upd_ack    one-clock pulse when shadow values become active
//   tick       registered prescaler strobe, aligned with the pulse outputs
//   cnt        current period count
//   pwm_set    one-clock set pulse per channel
//   pwm_reset  one-clock reset pulse per channel
//   signal     latched switch state per channel
module pwm_switch_array #(
    parameter int unsigned CH   = 4,
    parameter int unsigned W    = 7,
    parameter int unsigned DIV  = 25,
    parameter int unsigned DIVW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [W-1:0]      period,
    input  logic [CH*W-1:0]   set_val,
    input  logic [CH*W-1:0]   rst_val,
    input  logic              load,
    output logic              upd_ack,
    output logic              tick,
    output logic [W-1:0]      cnt,
    output logic [CH-1:0]     pwm_set,
    output logic [CH-1:0]     pwm_reset,
    output logic [CH-1:0]     signal
);

    localparam int unsigned CW = CH * W;

    // Prescaler and period counter
    logic [DIVW-1:0] r_div;
    logic [W-1:0]    r_cnt;

    // Active and shadow configuration
    logic [W-1:0]    r_period_a;
    logic [CW-1:0]   r_set_a;
    logic [CW-1:0]   r_rst_a;
    logic [W-1:0]    r_period_s;
    logic [CW-1:0]   r_set_s;
    logic [CW-1:0]   r_rst_s;
    logic            r_pending;

    // Registered outputs
    logic            r_tick;
    logic            r_upd_ack;
    logic [CH-1:0]   r_pwm_set;
    logic [CH-1:0]   r_pwm_reset;
    logic [CH-1:0]   r_signal;

    // Strobe, boundary and per-channel compare hits
    logic            w_s;
    logic            w_b;
    logic [CH-1:0]   w_set_hit;
    logic [CH-1:0]   w_rst_hit;

    assign w_s = en && (r_div == DIVW'(DIV - 1));
    assign w_b = w_s && (r_cnt == r_period_a);

    // Compare the pre-increment count against the active values; a compare
    // value above the active period can never match since cnt <= period_a.
    always_comb begin
        w_set_hit = '0;
        w_rst_hit = '0;
        for (int i = 0; i < int'(CH); i++) begin
            w_set_hit[i] = (r_cnt == r_set_a[i*W +: W]);
            w_rst_hit[i] = (r_cnt == r_rst_a[i*W +: W]);
        end
    end

    // Prescaler, counter, pulses and levels
    always_ff @(posedge clk) begin
        if (reset) begin
            r_div       <= '0;
            r_cnt       <= '0;
            r_tick      <= 1'b0;
            r_pwm_set   <= '0;
            r_pwm_reset <= '0;
            r_signal    <= '0;
        end else begin
            r_tick <= w_s;
            if (w_s) begin
                r_div       <= '0;
                r_cnt       <= (r_cnt == r_period_a) ? '0 : r_cnt + W'(1);
                r_pwm_set   <= w_set_hit;
                r_pwm_reset <= w_rst_hit;
                // reset match wins over set match
                r_signal    <= (r_signal | w_set_hit) & ~w_rst_hit;
            end else begin
                if (en) begin
                    r_div <= r_div + DIVW'(1);
                end
                r_pwm_set   <= '0;
                r_pwm_reset <= '0;
            end
        end
    end

    // Double-buffered configuration; a load on the boundary bypasses the shadow
    always_ff @(posedge clk) begin
        if (reset) begin
            r_period_a <= '0;
            r_set_a    <= '0;
            r_rst_a    <= '0;
            r_period_s <= '0;
            r_set_s    <= '0;
            r_rst_s    <= '0;
            r_pending  <= 1'b0;
            r_upd_ack  <= 1'b0;
        end else begin
            r_upd_ack <= 1'b0;
            if (w_b && load) begin
                r_period_a <= period;
                r_set_a    <= set_val;
                r_rst_a    <= rst_val;
                r_pending  <= 1'b0;
                r_upd_ack  <= 1'b1;
            end else if (w_b && r_pending) begin
                r_period_a <= r_period_s;
                r_set_a    <= r_set_s;
                r_rst_a    <= r_rst_s;
                r_pending  <= 1'b0;
                r_upd_ack  <= 1'b1;
            end else if (load) begin
                r_period_s <= period;
                r_set_s    <= set_val;
                r_rst_s    <= rst_val;
                r_pending  <= 1'b1;
            end
        end
    end

    assign upd_ack   = r_upd_ack;
    assign tick      = r_tick;
    assign cnt       = r_cnt;
    assign pwm_set   = r_pwm_set;
    assign pwm_reset = r_pwm_reset;
    assign signal    = r_signal;

endmodule

// File: doc/pwm_switch_array.md
Name: pwm_switch_array

Overview:
Multi-channel PWM pulse generator driving photonic-switch set/reset coils from a single core clock. A prescaler derives a tick strobe. The tick advances a shared period counter. Per-channel compare values generate one-cycle set and reset pulses plus a latched level output per channel. Compare and period values are double-buffered and take effect only at a period boundary, so updates never produce runt or glitched pulses.

Parameters:
CH, 4, number of switch channels
W, 7, period counter and compare value width
DIV, 25, prescaler terminal count; one tick every DIV clk cycles (200 MHz core -> 8 MHz tick)
DIVW, 5, prescaler counter width; must satisfy 2^DIVW >= DIV

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-high reset
en  in  1  run enable; low freezes prescaler, counter and levels
period  in  W  counter terminal value; period length = period+1 ticks
set_val  in  CH*W  per-channel set compare value; channel i occupies bits [i*W +: W]
rst_val  in  CH*W  per-channel reset compare value; same packing as set_val
load  in  1  capture period/set_val/rst_val into shadow registers
upd_ack  out  1  one-cycle pulse when shadow values become active
tick  out  1  registered prescaler strobe, aligned with the pulse outputs
cnt  out  W  current period count (active count)
pwm_set  out  CH  one-cycle set pulse per channel
pwm_reset  out  CH  one-cycle reset pulse per channel
signal  out  CH  latched switch state per channel

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high. All state updates on the rising edge of clk.
- Reset clears: div, cnt, active period/set/rst, shadow registers, pending flag, tick, upd_ack, pwm_set, pwm_reset and signal, all to 0.
- Prescaler: div counts 0..DIV-1 while en=1 and holds while en=0. Internal strobe s = en && (div==DIV-1). div wraps to 0 on s.
- Counter: on s, cnt <= (cnt==period_a) ? 0 : cnt+1. Otherwise cnt holds.
- Boundary: b = s && (cnt==period_a).
- Pulses are registered. On the edge where s=1:
  - pwm_set[i] <= (cnt==set_a[i]) and pwm_reset[i] <= (cnt==rst_a[i]), compared against the pre-increment cnt.
  - On all other edges both are 0.
  - tick <= s.
- Pulses therefore appear one clk after the strobe cycle and last exactly 1 clk.
- signal[i] updates on the same edge as its pulse registers:
  - rset match -> 0.
  - else set match -> 1.
  - else hold.
  - set_a == rst_a: both pulses are emitted and signal goes/stays 0 (reset wins).
- Compare value > period_a: never matches, so no pulse on that edge type and the level holds.
- Double buffering:
  - load=1 captures all inputs into the shadow registers and sets pending.
  - A repeated load while pending overwrites the shadow registers.
  - On b with pending=1: active <= shadow, pending <= 0, upd_ack <= 1 for 1 clk.
  - New values govern the compare starting with the count-0 tick.
  - The final-count compare of the old period uses the old values.
- load coinciding with b: input values bypass shadow straight to active, pending <= 0, upd_ack pulses.
- After reset, period_a=0, so every tick is a boundary and the first load applies at the next tick.
- en=0 mid-period: no strobes, pulses 0, signal and cnt hold. load is still captured; the transfer waits for the next boundary after en returns.
- reset mid-high: signal drops to 0 on the reset edge. Pending loads are discarded.
- Latency: set_val match to signal rise = 1 clk after the matching strobe cycle.

Test Plan:
- CH=2, DIV=25, load period=99, ch0 set=10 rst=60 after reset:
  - Expect pwm_set[0] every 2500 clk and pwm_reset[0] 1250 clk after each set.
  - Expect signal[0] high exactly 1250 clk, pulses 1 clk wide.
- ch1 set=79 rst=80: signal[1] high exactly 25 clk per period. set=80 rst=80: both pulses fire in the same cycle and signal[1] stays 0.
- Mid-period load (at cnt=40) of ch0 set=20 rst=30:
  - Old pattern completes.
  - upd_ack fires 1 clk after the cnt 99->0 strobe.
  - The next period shows signal high 250 clk.
  - load asserted on the exact boundary cycle also applies immediately.
- set_val=120 with period=99: no pwm_set ever and signal never rises. pwm_reset still fires at its compare value.
- en low for 300 clk while signal[0]=1:
  - cnt, div and signal frozen; no tick.
  - After en returns, the remaining high time equals the original minus the pre-pause portion.
- reset pulse while signal=1 with a pending load: all outputs 0 next edge, cnt=0, no upd_ack afterward until a new load.
